// File: rtl/sync_fifo_pkg.sv
// Shared defaults and pointer-width helper for the single-clock FIFO.
// Optional error flags are enabled with macro SYNC_FIFO_ERR_FLAGS_EN.
package sync_fifo_pkg;

    localparam int DATASIZE_DEF   = 8;
    localparam int ADDRSIZE_DEF   = 4;
    localparam int PTR_EXTRA_BITS = 1;

    // One extra pointer bit distinguishes a full FIFO from an empty one.
    function automatic int ptr_width(input int addrsize);
        return addrsize + PTR_EXTRA_BITS;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// FIFO storage: single-clock write port, asynchronous read port.
// Contents are deliberately not reset.
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int DATASIZE = DATASIZE_DEF,
    parameter int ADDRSIZE = ADDRSIZE_DEF
)(
    input  logic                clk,
    input  logic                we,
    input  logic [ADDRSIZE-1:0] waddr,
    input  logic [DATASIZE-1:0] wdata,
    input  logic [ADDRSIZE-1:0] raddr,
    output logic [DATASIZE-1:0] rdata
);

    logic [DATASIZE-1:0] mem [0:(2**ADDRSIZE)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, occupancy count and threshold flags.
// Define SYNC_FIFO_ERR_FLAGS_EN to add err_clr input and sticky ovf/unf outputs.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATASIZE   = DATASIZE_DEF,
    parameter int ADDRSIZE   = ADDRSIZE_DEF,
    parameter int AFULL_LVL  = (2**ADDRSIZE) - 2,
    parameter int AEMPTY_LVL = 2
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                winc,
    input  logic [DATASIZE-1:0] wdata,
    input  logic                rinc,
    output logic [DATASIZE-1:0] rdata,
    output logic                wfull,
    output logic                rempty,
    output logic                afull,
    output logic                aempty,
    output logic [ADDRSIZE:0]   count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    input  logic                err_clr,
    output logic                ovf,
    output logic                unf
`endif
);

    localparam int PTRW = ptr_width(ADDRSIZE);
    localparam logic [PTRW-1:0] AFULL_THR  = PTRW'(AFULL_LVL);
    localparam logic [PTRW-1:0] AEMPTY_THR = PTRW'(AEMPTY_LVL);

    logic [PTRW-1:0]     wptr, rptr, wptr_next, rptr_next, count_next;
    logic                wr_ok, rd_ok;
    logic [DATASIZE-1:0] ram_rdata;

    // A full FIFO still accepts a write when a read frees a slot on the same edge;
    // an empty FIFO never bypasses write data to a read.
    always_comb begin
        wr_ok      = winc && (!wfull || rinc);
        rd_ok      = rinc && !rempty;
        wptr_next  = wptr + PTRW'(wr_ok);
        rptr_next  = rptr + PTRW'(rd_ok);
        count_next = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    sync_fifo_ram #(
        .DATASIZE (DATASIZE),
        .ADDRSIZE (ADDRSIZE)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wptr[ADDRSIZE-1:0]),
        .wdata (wdata),
        .raddr (rptr[ADDRSIZE-1:0]),
        .rdata (ram_rdata)
    );

    // Flags are registered from next-state pointers/count so they line up with them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            rdata  <= '0;
            wfull  <= 1'b0;
            rempty <= 1'b1;
            afull  <= 1'b0;
            aempty <= 1'b1;
        end else begin
            wptr   <= wptr_next;
            rptr   <= rptr_next;
            count  <= count_next;
            if (rd_ok) begin
                rdata <= ram_rdata;
            end
            wfull  <= (wptr_next[PTRW-1] != rptr_next[PTRW-1]) &&
                      (wptr_next[ADDRSIZE-1:0] == rptr_next[ADDRSIZE-1:0]);
            rempty <= (wptr_next == rptr_next);
            afull  <= (count_next >= AFULL_THR);
            aempty <= (count_next <= AEMPTY_THR);
        end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    // Sticky error flags; a new error on the clearing edge keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (winc && !wr_ok) begin
                ovf <= 1'b1;
            end else if (err_clr) begin
                ovf <= 1'b0;
            end
            if (rinc && !rd_ok) begin
                unf <= 1'b1;
            end else if (err_clr) begin
                unf <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Randomized self-checking bench for sync_fifo against a queue-based reference model.
// Also checks ovf/unf when SYNC_FIFO_ERR_FLAGS_EN is defined.
module tb_sync_fifo;

    localparam int DATASIZE = 8;
    localparam int ADDRSIZE = 4;
    localparam int DEPTH    = 16;

    logic                clk   = 1'b0;
    logic                rst_n = 1'b1;
    logic                winc  = 1'b0;
    logic                rinc  = 1'b0;
    logic [DATASIZE-1:0] wdata = '0;
    logic [DATASIZE-1:0] rdata;
    logic                wfull, rempty, afull, aempty;
    logic [ADDRSIZE:0]   count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic                err_clr = 1'b0;
    logic                ovf, unf;
    logic                expOvf  = 1'b0;
    logic                expUnf  = 1'b0;
`endif

    int                  checks = 0;
    int                  passes = 0;
    logic [DATASIZE-1:0] modelQ[$];
    logic [DATASIZE-1:0] expRdata = '0;

    always #5 clk = ~clk;

    sync_fifo dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .winc    (winc),
        .wdata   (wdata),
        .rinc    (rinc),
        .rdata   (rdata),
        .wfull   (wfull),
        .rempty  (rempty),
        .afull   (afull),
        .aempty  (aempty),
        .count   (count)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        ,
        .err_clr (err_clr),
        .ovf     (ovf),
        .unf     (unf)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compareAll();
        int n;
        n = modelQ.size();
        checkOutput("count",  32'(count),  32'(n));
        checkOutput("rdata",  32'(rdata),  32'(expRdata));
        checkOutput("wfull",  32'(wfull),  32'(n == DEPTH));
        checkOutput("rempty", 32'(rempty), 32'(n == 0));
        checkOutput("afull",  32'(afull),  32'(n >= DEPTH - 2));
        checkOutput("aempty", 32'(aempty), 32'(n <= 2));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        checkOutput("ovf",    32'(ovf),    32'(expOvf));
        checkOutput("unf",    32'(unf),    32'(expUnf));
`endif
    endtask

    task automatic modelReset();
        modelQ.delete();
        expRdata = '0;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        expOvf = 1'b0;
        expUnf = 1'b0;
`endif
    endtask

    // One clock of stimulus: the model decides acceptance from the occupancy before the edge.
    task automatic applyStimulus(input logic w, input logic [DATASIZE-1:0] d, input logic r);
        bit full, empty, wAcc, rAcc;
        full  = (modelQ.size() == DEPTH);
        empty = (modelQ.size() == 0);
        wAcc  = w && (!full || r);
        rAcc  = r && !empty;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        if (w && !wAcc) expOvf = 1'b1;
        else if (err_clr) expOvf = 1'b0;
        if (r && !rAcc) expUnf = 1'b1;
        else if (err_clr) expUnf = 1'b0;
`endif
        if (rAcc) expRdata = modelQ.pop_front();
        if (wAcc) modelQ.push_back(d);
        winc  = w;
        wdata = d;
        rinc  = r;
        @(posedge clk);
        #1;
        winc = 1'b0;
        rinc = 1'b0;
        compareAll();
    endtask

    initial begin
        // Power-on reset
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        compareAll();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Asynchronous reset with 5 words stored, checked before any clock edge
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'($urandom), 1'b0);
        rst_n = 1'b0;
        #2;
        modelReset();
        compareAll();
        @(negedge clk);
        rst_n = 1'b1;

        // Fill with 0x00..0x0F, try one rejected write, then drain in order
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'(i), 1'b0);
        applyStimulus(1'b1, 8'hEE, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            checkOutput("drain_order", 32'(rdata), 32'(i));
        end
        applyStimulus(1'b0, 8'h00, 1'b1);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
        // Set wins over clear, then a plain clear
        err_clr = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        err_clr = 1'b0;
        checkOutput("err_cleared", 32'({ovf, unf}), 32'(0));
`endif

        // Full with simultaneous read and write of 0xAA
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'($urandom), 1'b0);
        applyStimulus(1'b1, 8'hAA, 1'b1);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("full_rw_aa", 32'(rdata), 32'h0000_00AA);

        // Empty with simultaneous read and write of 0x55: read is rejected
        applyStimulus(1'b1, 8'h55, 1'b1);
        checkOutput("empty_rw_rdata_held", 32'(rdata), 32'h0000_00AA);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("empty_rw_55", 32'(rdata), 32'h0000_0055);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
        err_clr = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0);
        err_clr = 1'b0;
`endif

        // Wrap-around: 40 write/read pairs across several pointer-MSB wraps
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 8'($urandom), 1'b0);
            applyStimulus(1'b0, 8'h00, 1'b1);
        end

        // Random traffic biased to visit both full and empty
        for (int i = 0; i < 400; i++) begin
            if ((i / 50) % 2 == 0)
                applyStimulus(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 3) == 0));
            else
                applyStimulus(1'($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
